// File: rtl/fir_wb_accel_if.sv
// Wishbone slave bus bundle for the FIR accelerator.
// Signal names follow the SoC user-project wishbone naming.
interface fir_wb_accel_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/fir_wb_accel.sv
// Wishbone-slave FIR accelerator: one MAC per cycle, y[n] = sum h[i]*x[n-i].
// Optional macro FIR_CHECKBIT_EN adds the 16-bit progress code checkbits_o.
//
// state     | meaning
// ST_IDLE   | waiting for a start; ap_idle=1
// ST_WAIT_X | waiting for one input sample; x_ready=1
// ST_MAC    | accumulating NUM_TAPS products, one per cycle
// ST_HOLD_Y | result in y buffer; y_valid=1 until firmware reads Y
module fir_wb_accel #(
  parameter int          NUM_TAPS  = 11,
  parameter int          DATA_W    = 32,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  fir_wb_accel_if.slave wbs
`ifdef FIR_CHECKBIT_EN
  ,
  output logic [15:0]   checkbits_o
`endif
);

  localparam int          IDX_W    = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam logic [5:0]  LP_NTAPS = 6'(NUM_TAPS);
  localparam logic [7:0]  OFF_CTRL = 8'h00;
  localparam logic [7:0]  OFF_LEN  = 8'h10;
  localparam logic [7:0]  OFF_X    = 8'h80;
  localparam logic [7:0]  OFF_Y    = 8'h84;
  localparam logic [5:0]  TAP_WORD = 6'd16;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT_X, ST_MAC, ST_HOLD_Y} state_t;

  state_t             r_state, w_state_nxt;
  logic               r_ack;
  logic [31:0]        r_dat_o;
  logic [31:0]        r_len;
  logic [31:0]        r_out_cnt;
  logic               r_done;
  logic [DATA_W-1:0]  r_taps  [NUM_TAPS];
  logic [DATA_W-1:0]  r_xline [NUM_TAPS];
  logic [DATA_W-1:0]  r_acc;
  logic [DATA_W-1:0]  r_ybuf;
  logic [IDX_W-1:0]   r_mac_cnt;

  logic [7:0]         w_off;
  logic [5:0]         w_word;
  logic [5:0]         w_tap_rel;
  logic [IDX_W-1:0]   w_tap_idx;
  logic               w_req, w_hit_ctrl, w_hit_len, w_hit_x, w_hit_y, w_hit_tap;
  logic               w_busy, w_idle, w_x_ready, w_y_valid;
  logic               w_len_zero, w_last_y;
  logic               w_fire, w_start, w_x_acc, w_y_pop, w_mac_last, w_set_done;
  logic [31:0]        w_rdata;
  logic [DATA_W-1:0]  w_prod;
  logic               w_unused_sel;

  // Byte enables are ignored: every access is treated as a full word.
  assign w_unused_sel = ^wbs.wbs_sel_i;

  // A request already acknowledged is masked so each transfer gets a single ack.
  assign w_off      = wbs.wbs_adr_i[7:0];
  assign w_word     = wbs.wbs_adr_i[7:2];
  assign w_tap_rel  = w_word - TAP_WORD;
  assign w_tap_idx  = IDX_W'(w_tap_rel);
  assign w_req      = wbs.wbs_cyc_i & wbs.wbs_stb_i & ~r_ack &
                      (wbs.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign w_hit_ctrl = (w_off == OFF_CTRL);
  assign w_hit_len  = (w_off == OFF_LEN);
  assign w_hit_x    = (w_off == OFF_X);
  assign w_hit_y    = (w_off == OFF_Y);
  assign w_hit_tap  = (w_off[1:0] == 2'b00) && (w_word >= TAP_WORD) &&
                      (w_tap_rel < LP_NTAPS) && !w_hit_x && !w_hit_y;

  assign w_idle     = (r_state == ST_IDLE);
  assign w_busy     = !w_idle;
  assign w_x_ready  = (r_state == ST_WAIT_X);
  assign w_y_valid  = (r_state == ST_HOLD_Y);
  assign w_len_zero = (r_len == 32'd0);
  assign w_last_y   = ((r_out_cnt + 32'd1) == r_len);

  // Low word of a signed product is all the accumulator keeps (wraps mod 2^32).
  assign w_prod = $signed(r_taps[r_mac_cnt]) * $signed(r_xline[r_mac_cnt]);

  // State register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state, bus wait-state decision and sequencing strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_fire      = 1'b0;
    w_start     = 1'b0;
    w_x_acc     = 1'b0;
    w_y_pop     = 1'b0;
    w_mac_last  = 1'b0;
    w_set_done  = 1'b0;
    if (w_req) begin
      w_fire = 1'b1;
      if (w_hit_x && wbs.wbs_we_i && w_busy && !w_x_ready)  w_fire = 1'b0;
      if (w_hit_y && !wbs.wbs_we_i && w_busy && !w_y_valid) w_fire = 1'b0;
    end
    case (r_state)
      ST_IDLE: begin
        if (w_fire && wbs.wbs_we_i && w_hit_ctrl && wbs.wbs_dat_i[0]) begin
          w_start = 1'b1;
          if (w_len_zero) w_set_done  = 1'b1;
          else            w_state_nxt = ST_WAIT_X;
        end
      end
      ST_WAIT_X: begin
        if (w_fire && wbs.wbs_we_i && w_hit_x) begin
          w_x_acc     = 1'b1;
          w_state_nxt = ST_MAC;
        end
      end
      ST_MAC: begin
        if (r_mac_cnt == '0) begin
          w_mac_last  = 1'b1;
          w_state_nxt = ST_HOLD_Y;
        end
      end
      ST_HOLD_Y: begin
        if (w_fire && !wbs.wbs_we_i && w_hit_y) begin
          w_y_pop = 1'b1;
          if (w_last_y) begin
            w_set_done  = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_WAIT_X;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Read data mux; Y returns the buffer, which in idle is the last popped value.
  always_comb begin
    w_rdata = '0;
    if (w_hit_ctrl)     w_rdata = {26'd0, w_y_valid, w_x_ready, 1'b0, w_idle, r_done, 1'b0};
    else if (w_hit_len) w_rdata = r_len;
    else if (w_hit_y)   w_rdata = r_ybuf;
    else if (w_hit_tap) w_rdata = r_taps[w_tap_idx];
  end

  // Registered ack pulse and read data.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_ack   <= 1'b0;
      r_dat_o <= '0;
    end else begin
      r_ack <= w_fire;
      if (w_fire) r_dat_o <= wbs.wbs_we_i ? 32'd0 : w_rdata;
    end
  end

  assign wbs.wbs_ack_o = r_ack;
  assign wbs.wbs_dat_o = r_dat_o;

  // Configuration registers; frozen while a run is in progress.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_len <= '0;
      for (int i = 0; i < NUM_TAPS; i++) r_taps[i] <= '0;
    end else if (w_fire && wbs.wbs_we_i && w_idle) begin
      if (w_hit_len) r_len <= wbs.wbs_dat_i;
      if (w_hit_tap) r_taps[w_tap_idx] <= wbs.wbs_dat_i;
    end
  end

  // Shift line, newest sample at index 0; cleared at start so x[k<0]=0.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || w_start) begin
      for (int i = 0; i < NUM_TAPS; i++) r_xline[i] <= '0;
    end else if (w_x_acc) begin
      r_xline[0] <= wbs.wbs_dat_i;
      for (int i = 1; i < NUM_TAPS; i++) r_xline[i] <= r_xline[i-1];
    end
  end

  // MAC down-counter, accumulator and y buffer.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_mac_cnt <= '0;
      r_acc     <= '0;
      r_ybuf    <= '0;
    end else if (w_x_acc) begin
      r_mac_cnt <= IDX_W'(NUM_TAPS - 1);
      r_acc     <= '0;
    end else if (r_state == ST_MAC) begin
      r_acc <= r_acc + w_prod;
      if (w_mac_last) r_ybuf    <= r_acc + w_prod;
      else            r_mac_cnt <= r_mac_cnt - 1'b1;
    end
  end

  // Output counter and ap_done.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_out_cnt <= '0;
      r_done    <= 1'b0;
    end else begin
      if (w_start)      r_out_cnt <= '0;
      else if (w_y_pop) r_out_cnt <= r_out_cnt + 32'd1;
      if (w_set_done)   r_done <= 1'b1;
      else if (w_start) r_done <= 1'b0;
    end
  end

`ifdef FIR_CHECKBIT_EN
  logic [15:0] r_checkbits;

  // Progress code: AB00 once a run starts, AB01 when it completes.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)        r_checkbits <= 16'h0000;
    else if (w_set_done) r_checkbits <= 16'hAB01;
    else if (w_start)    r_checkbits <= 16'hAB00;
  end

  assign checkbits_o = r_checkbits;
`endif

endmodule

// File: tb/tb_fir_wb_accel.sv
// Self-checking bench for fir_wb_accel: a convolution model in plain integer
// arithmetic predicts every read; one monitor process checks each ack.
module tb_fir_wb_accel;
  localparam int          NT     = 11;
  localparam logic [31:0] BASE   = 32'h3000_0000;
  localparam logic [7:0]  A_CTRL = 8'h00;
  localparam logic [7:0]  A_LEN  = 8'h10;
  localparam logic [7:0]  A_X    = 8'h80;
  localparam logic [7:0]  A_Y    = 8'h84;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fir_wb_accel_if bus();
`ifdef FIR_CHECKBIT_EN
  logic [15:0] cb;
`endif

  fir_wb_accel #(.NUM_TAPS(NT), .DATA_W(32), .BASE_ADDR(BASE)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wbs      (bus)
`ifdef FIR_CHECKBIT_EN
    ,
    .checkbits_o (cb)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  int          m_taps [NT];
  int          m_x    [$];
  logic [31:0] m_last_y;
  int          sym    [NT] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};

  // Expectation handed from the driver to the monitor
  bit          cur_chk = 1'b0;
  logic [31:0] cur_exp = '0;
  string       cur_nm  = "";
  bit          mon_prev_ack;

  function automatic int model_y(input int n);
    int s;
    s = 0;
    for (int i = 0; i < NT; i++)
      if (n - i >= 0) s += m_taps[i] * m_x[n - i];
    return s;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
    end
  endtask

  task automatic xfer(input bit we, input logic [7:0] off, input logic [31:0] wd,
                      input int budget, output logic [31:0] rdat, output bit ok,
                      output int ncyc);
    @(negedge clk);
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = we;
    bus.wbs_sel_i = 4'hF;
    bus.wbs_adr_i = {BASE[31:8], off};
    bus.wbs_dat_i = wd;
    ok   = 1'b0;
    ncyc = 0;
    rdat = '0;
    while (!ok && ncyc < budget) begin
      @(posedge clk); #1;
      ncyc++;
      if (bus.wbs_ack_o) begin
        ok   = 1'b1;
        rdat = bus.wbs_dat_o;
      end
    end
    #1;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    cur_chk       = 1'b0;
  endtask

  task automatic wr_reg(input logic [7:0] off, input logic [31:0] d, input string nm);
    logic [31:0] r;
    bit ok;
    int n;
    xfer(1'b1, off, d, 50, r, ok, n);
    chk({nm, "_ack"}, {31'd0, ok}, 32'd1);
  endtask

  task automatic rd_reg(input logic [7:0] off, input logic [31:0] exp, input string nm);
    logic [31:0] r;
    bit ok;
    int n;
    cur_nm  = nm;
    cur_exp = exp;
    cur_chk = 1'b1;
    xfer(1'b0, off, 32'd0, 50, r, ok, n);
    chk({nm, "_ack"}, {31'd0, ok}, 32'd1);
  endtask

  task automatic expect_hold(input bit we, input logic [7:0] off, input string nm);
    logic [31:0] r;
    bit ok;
    int n;
    xfer(we, off, 32'd0, 30, r, ok, n);
    chk(nm, {31'd0, ok}, 32'd0);
  endtask

  task automatic load_taps();
    for (int i = 0; i < NT; i++) wr_reg(8'h40 + 8'(4 * i), m_taps[i], "tap_wr");
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NT; i++) m_taps[i] = 0;
    m_last_y = '0;
  endtask

  // Full run over the samples in m_x; optionally pokes config while busy.
  task automatic run_fir(input string tag, input bit pokes);
    int len;
    len = m_x.size();
    wr_reg(A_LEN, len, "len_wr");
    wr_reg(A_CTRL, 32'd1, "start");
    if (pokes) begin
      wr_reg(8'h40, 32'd99, "busy_tap_wr");
      wr_reg(A_LEN, 32'd77, "busy_len_wr");
      wr_reg(A_CTRL, 32'd1, "busy_start");
      rd_reg(8'h40, m_taps[0], {tag, "_tap0_kept"});
      rd_reg(A_LEN, len, {tag, "_len_kept"});
    end
    rd_reg(A_CTRL, 32'h10, {tag, "_ctrl_busy"});
`ifdef FIR_CHECKBIT_EN
    chk({tag, "_cb_start"}, {16'd0, cb}, 32'h0000_AB00);
`endif
    for (int n = 0; n < len; n++) begin
      wr_reg(A_X, m_x[n], {tag, "_x"});
      m_last_y = model_y(n);
      rd_reg(A_Y, m_last_y, {tag, "_y"});
    end
    rd_reg(A_CTRL, 32'h6, {tag, "_ctrl_done"});
`ifdef FIR_CHECKBIT_EN
    chk({tag, "_cb_done"}, {16'd0, cb}, 32'h0000_AB01);
`endif
    rd_reg(A_Y, m_last_y, {tag, "_y_idle"});
  endtask

  // Monitor: every ack must answer a live request, last one cycle, and carry
  // the model's read data when the driver supplied an expectation.
  initial begin
    mon_prev_ack = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (bus.wbs_ack_o) begin
        chk("ack_has_req", {31'd0, bus.wbs_cyc_i & bus.wbs_stb_i}, 32'd1);
        chk("ack_pulse", {31'd0, mon_prev_ack}, 32'd0);
        if (!bus.wbs_we_i && cur_chk) chk(cur_nm, bus.wbs_dat_o, cur_exp);
      end
      mon_prev_ack = bus.wbs_ack_o;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    bit ok;
    int n;
    int len;

    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_sel_i = 4'h0;
    bus.wbs_adr_i = '0;
    bus.wbs_dat_i = '0;
    for (int i = 0; i < NT; i++) m_taps[i] = 0;
    m_last_y = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    rd_reg(A_CTRL, 32'h4, "rst_ctrl");
    for (int i = 0; i < NT; i++) rd_reg(8'h40 + 8'(4 * i), 32'd0, "rst_tap");
    rd_reg(A_LEN, 32'd0, "rst_len");
    rd_reg(A_Y, 32'd0, "rst_y");
    rd_reg(8'h20, 32'd0, "unmapped");
`ifdef FIR_CHECKBIT_EN
    chk("rst_cb", {16'd0, cb}, 32'd0);
`endif

    // Tap program h[i]=i, readback, run with LEN=3 and busy pokes
    for (int i = 0; i < NT; i++) m_taps[i] = i;
    load_taps();
    for (int i = 0; i < NT; i++) rd_reg(8'h40 + 8'(4 * i), i, "tap_rb");
    m_x = {};
    for (int i = 0; i < 3; i++) m_x.push_back(int'($urandom_range(0, 1000)) - 500);
    run_fir("ramp", 1'b1);

    // All taps 1, x[n]=n+1
    for (int i = 0; i < NT; i++) m_taps[i] = 1;
    load_taps();
    m_x = {};
    for (int i = 0; i < 12; i++) m_x.push_back(i + 1);
    chk("lit_y0", model_y(0), 32'd1);
    chk("lit_y1", model_y(1), 32'd3);
    chk("lit_y10", model_y(10), 32'd66);
    chk("lit_y11", model_y(11), 32'd77);
    run_fir("ones", 1'b0);

    // Symmetric signed taps
    for (int i = 0; i < NT; i++) m_taps[i] = sym[i];
    load_taps();
    m_x = {0, 1, 2, 3};
    chk("lit_s0", model_y(0), 32'd0);
    chk("lit_s1", model_y(1), 32'd0);
    chk("lit_s2", model_y(2), 32'hFFFF_FFF6);
    chk("lit_s3", model_y(3), 32'hFFFF_FFE3);
    run_fir("sym", 1'b0);

    // Flow control: second X held until Y read; Y read waits out the MAC
    m_x = {};
    for (int i = 0; i < 2; i++) m_x.push_back(int'($urandom()));
    wr_reg(A_LEN, 32'd2, "fc_len");
    wr_reg(A_CTRL, 32'd1, "fc_start");
    wr_reg(A_X, m_x[0], "fc_x0");
    expect_hold(1'b1, A_X, "fc_x1_held");
    m_last_y = model_y(0);
    rd_reg(A_Y, m_last_y, "fc_y0");
    wr_reg(A_X, m_x[1], "fc_x1");
    m_last_y = model_y(1);
    cur_nm  = "fc_y1";
    cur_exp = m_last_y;
    cur_chk = 1'b1;
    xfer(1'b0, A_Y, 32'd0, 50, r, ok, n);
    chk("fc_y1_ack", {31'd0, ok}, 32'd1);
    chk("fc_y1_waited", {31'd0, n >= NT}, 32'd1);
    rd_reg(A_CTRL, 32'h6, "fc_ctrl_done");

    // Y read before any x is accepted
    m_x = {int'($urandom())};
    wr_reg(A_LEN, 32'd1, "fc2_len");
    wr_reg(A_CTRL, 32'd1, "fc2_start");
    expect_hold(1'b0, A_Y, "fc2_y_held");
    wr_reg(A_X, m_x[0], "fc2_x");
    m_last_y = model_y(0);
    rd_reg(A_Y, m_last_y, "fc2_y");
    rd_reg(A_CTRL, 32'h6, "fc2_ctrl_done");

    // Randomized runs with full-range taps and samples
    for (int run = 0; run < 4; run++) begin
      for (int i = 0; i < NT; i++)
        m_taps[i] = ($urandom_range(0, 1) != 0) ? int'($urandom())
                                                : int'($urandom_range(0, 64)) - 32;
      load_taps();
      len = int'($urandom_range(1, 6));
      m_x = {};
      for (int i = 0; i < len; i++) m_x.push_back(int'($urandom()));
      run_fir("rand", run == 0);
    end

    // Reset mid-run aborts everything
    wr_reg(A_LEN, 32'd5, "ab_len");
    wr_reg(A_CTRL, 32'd1, "ab_start");
    wr_reg(A_X, 32'd1234, "ab_x");
    do_reset();
    rd_reg(A_CTRL, 32'h4, "ab_ctrl");
    rd_reg(A_Y, 32'd0, "ab_y");
    rd_reg(8'h4C, 32'd0, "ab_tap3");
    rd_reg(A_LEN, 32'd0, "ab_len_rd");
`ifdef FIR_CHECKBIT_EN
    chk("ab_cb", {16'd0, cb}, 32'd0);
`endif

    // Start with LEN=0 completes immediately
    wr_reg(A_CTRL, 32'd1, "z_start");
    rd_reg(A_CTRL, 32'h6, "z_ctrl_done");
`ifdef FIR_CHECKBIT_EN
    chk("z_cb", {16'd0, cb}, 32'h0000_AB01);
`endif

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
